// File: rtl/traffic_pkg.sv
// Shared phase codes and request-FSM encoding, used by the request unit and the intersection controller.
package traffic_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    N_GREEN  = 3'd0,
    N_YELLOW = 3'd1,
    E_GREEN  = 3'd2,
    E_YELLOW = 3'd3,
    S_GREEN  = 3'd4,
    S_YELLOW = 3'd5,
    W_GREEN  = 3'd6,
    N_LEFT   = 3'd7
  } phase_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    ASSERT = 2'd2,
    DRAIN  = 2'd3
  } req_state_t;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer; emits a one-cycle pulse on a debounced rise.
module input_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] count;

  // The count only runs while the synchronized value disagrees with the debounced
  // level, and it is capped at LAST, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      count <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        count <= '0;
      end else if (count == LAST) begin
        level <= sync2;
        rise  <= sync2;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_request_unit.sv
// Debounces sensor/emergency pads, latches requests and issues them to the controller once north green
// has run its minimum time (emergency bypasses the wait).
module traffic_request_unit
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 16,
  parameter int unsigned MIN_GREEN_CYCLES = 500
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sensor_raw,
  input  logic       emerg_raw,
  input  logic [2:0] phase,
  output logic [1:0] go_control,
  output logic       req_pending,
  output logic       emerg_active
);

  localparam logic [CNT_W-1:0] MG_LIMIT = CNT_W'(MIN_GREEN_CYCLES);

  logic             sensor_rise;
  logic             emerg_rise;
  logic             sensor_req;
  logic             emerg_req;
  logic             sensor_next;
  logic             emerg_next;
  logic             any_next;
  logic             north_green;
  logic             consume;
  logic [CNT_W-1:0] mg_count;
  req_state_t       state;

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sensor_db (
    .clk    (clk),
    .resetn (resetn),
    .raw    (sensor_raw),
    .rise   (sensor_rise)
  );

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_emerg_db (
    .clk    (clk),
    .resetn (resetn),
    .raw    (emerg_raw),
    .rise   (emerg_rise)
  );

  assign north_green = (phase == N_GREEN);
  assign consume     = (state == ASSERT) && !north_green;

  // A rise arriving on the consuming edge keeps its latch set.
  assign sensor_next = sensor_rise | (sensor_req & ~consume);
  assign emerg_next  = emerg_rise  | (emerg_req  & ~consume);
  assign any_next    = sensor_next | emerg_next;

  assign req_pending  = sensor_req | emerg_req;
  assign emerg_active = emerg_req;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sensor_req <= 1'b0;
      emerg_req  <= 1'b0;
      mg_count   <= '0;
    end else begin
      sensor_req <= sensor_next;
      emerg_req  <= emerg_next;
      if (!north_green) begin
        mg_count <= '0;
      end else if (mg_count != MG_LIMIT) begin
        mg_count <= mg_count + 1'b1;
      end
    end
  end

  // go_control is computed from next-cycle latch values so it tracks the
  // latches exactly while in ASSERT and is zero elsewhere.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      go_control <= 2'b00;
    end else begin
      go_control <= 2'b00;
      case (state)
        IDLE: begin
          if (any_next) state <= HOLD;
        end
        HOLD: begin
          if (north_green && (emerg_next || mg_count == MG_LIMIT)) begin
            state      <= ASSERT;
            go_control <= {emerg_next, sensor_next};
          end
        end
        ASSERT: begin
          if (!north_green) begin
            state <= DRAIN;
          end else begin
            go_control <= {emerg_next, sensor_next};
          end
        end
        DRAIN: begin
          if (north_green) state <= any_next ? HOLD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_request_unit.sv
// Directed scoreboard bench: each step queues the outputs expected on a given cycle, a negedge checker compares them.
module tb_traffic_request_unit;

  typedef struct {
    int         due;
    logic [3:0] exp;
    string      tag;
  } expect_t;

  logic       clk;
  logic       resetn;
  logic       sensorRaw;
  logic       emergRaw;
  logic [2:0] phase;
  logic [1:0] goControl;
  logic       reqPending;
  logic       emergActive;

  int      cycle;
  int      checks;
  int      errors;
  expect_t sbQueue[$];

  traffic_request_unit #(
    .DEBOUNCE_CYCLES  (4),
    .MIN_GREEN_CYCLES (10)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sensor_raw   (sensorRaw),
    .emerg_raw    (emergRaw),
    .phase        (phase),
    .go_control   (goControl),
    .req_pending  (reqPending),
    .emerg_active (emergActive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic applyStimulus(input logic s, input logic e, input logic [2:0] p, input logic rn);
    sensorRaw = s;
    emergRaw  = e;
    phase     = p;
    resetn    = rn;
  endtask

  task automatic expectAt(input int due, input logic [1:0] go, input logic pend, input logic em,
                          input string tag);
    expect_t item;
    item.due = due;
    item.exp = {go, pend, em};
    item.tag = tag;
    sbQueue.push_back(item);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {goControl, reqPending, emergActive};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s @cycle %0d: observed go/pend/emerg=%b required %b", tag, cycle, obs, exp);
    end
  endtask

  task automatic waitUntil(input int c);
    while (cycle < c) @(negedge clk);
  endtask

  // Pop every queued expectation that falls due on this cycle.
  always @(negedge clk) begin
    int idx;
    idx = 0;
    while (idx < sbQueue.size()) begin
      if (sbQueue[idx].due == cycle) begin
        checkOutput(sbQueue[idx].tag, sbQueue[idx].exp);
        sbQueue.delete(idx);
      end else begin
        idx++;
      end
    end
  end

  initial begin
    int t;
    int g;
    int p;
    int q;
    int r;
    int guard;
    cycle  = 0;
    checks = 0;
    errors = 0;
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    $display("[TB] start");

    expectAt(2, 2'b00, 1'b0, 1'b0, "reset_state");
    waitUntil(3);
    resetn = 1'b1;

    // Sensor edge with min-green long saturated: go after 4+4 cycles.
    t = 25;
    expectAt(t + 6,  2'b00, 1'b0, 1'b0, "lat_pre_deb");
    expectAt(t + 7,  2'b00, 1'b1, 1'b0, "lat_latch");
    expectAt(t + 8,  2'b01, 1'b1, 1'b0, "lat_go");
    expectAt(t + 10, 2'b01, 1'b1, 1'b0, "assert_hold");
    expectAt(t + 11, 2'b00, 1'b0, 1'b0, "assert_consume");
    expectAt(t + 13, 2'b00, 1'b0, 1'b0, "drain_idle");
    waitUntil(t);
    sensorRaw = 1'b1;
    waitUntil(t + 10);
    phase = 3'd1;
    waitUntil(t + 11);
    sensorRaw = 1'b0;
    waitUntil(t + 12);
    phase = 3'd0;

    // Three-cycle glitch never debounces.
    g = t + 20;
    expectAt(g + 4,  2'b00, 1'b0, 1'b0, "glitch_a");
    expectAt(g + 8,  2'b00, 1'b0, 1'b0, "glitch_b");
    expectAt(g + 12, 2'b00, 1'b0, 1'b0, "glitch_c");
    waitUntil(g);
    sensorRaw = 1'b1;
    waitUntil(g + 3);
    sensorRaw = 1'b0;

    // Phase re-enters 0; sensor debounces 2 cycles later and waits for min-green.
    p = g + 10;
    waitUntil(p - 2);
    expectAt(p + 5,  2'b00, 1'b1, 1'b0, "mg_latch");
    expectAt(p + 12, 2'b00, 1'b1, 1'b0, "mg_wait");
    expectAt(p + 13, 2'b01, 1'b1, 1'b0, "mg_go");
    expectAt(p + 16, 2'b00, 1'b0, 1'b0, "mg_consume");
    sensorRaw = 1'b1;
    waitUntil(p);
    phase = 3'd2;
    waitUntil(p + 2);
    phase = 3'd0;
    waitUntil(p + 15);
    phase = 3'd1;
    waitUntil(p + 16);
    sensorRaw = 1'b0;

    // Sensor waiting in HOLD, then emergency bypasses min-green.
    q = p + 24;
    waitUntil(q);
    expectAt(q + 1,  2'b00, 1'b0, 1'b0, "drain_to_idle");
    expectAt(q + 7,  2'b00, 1'b1, 1'b0, "hold_sensor");
    expectAt(q + 8,  2'b00, 1'b1, 1'b0, "hold_wait");
    expectAt(q + 9,  2'b11, 1'b1, 1'b1, "emerg_go");
    expectAt(q + 10, 2'b11, 1'b1, 1'b1, "emerg_hold");
    expectAt(q + 12, 2'b00, 1'b0, 1'b0, "reset_mid");
    expectAt(q + 18, 2'b00, 1'b0, 1'b0, "post_reset_deb");
    expectAt(q + 19, 2'b00, 1'b1, 1'b1, "post_reset_latch");
    expectAt(q + 20, 2'b11, 1'b1, 1'b1, "post_reset_go");
    phase     = 3'd0;
    sensorRaw = 1'b1;
    waitUntil(q + 2);
    emergRaw = 1'b1;
    waitUntil(q + 11);
    resetn = 1'b0;
    waitUntil(q + 12);
    resetn = 1'b1;

    // Sensor edge during DRAIN latches but is only reissued after min-green.
    r = q + 21;
    waitUntil(r);
    expectAt(r + 1,  2'b00, 1'b0, 1'b0, "drain_enter");
    expectAt(r + 14, 2'b00, 1'b0, 1'b0, "drain_pre_latch");
    expectAt(r + 15, 2'b00, 1'b1, 1'b0, "drain_latch");
    expectAt(r + 18, 2'b00, 1'b1, 1'b0, "drain_no_issue");
    expectAt(r + 21, 2'b00, 1'b1, 1'b0, "drain_hold");
    expectAt(r + 30, 2'b00, 1'b1, 1'b0, "reissue_wait");
    expectAt(r + 31, 2'b01, 1'b1, 1'b0, "reissue_go");
    applyStimulus(1'b0, 1'b0, 3'd3, 1'b1);
    waitUntil(r + 8);
    sensorRaw = 1'b1;
    waitUntil(r + 20);
    phase = 3'd0;

    guard = 0;
    while (sbQueue.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    if (sbQueue.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sbQueue.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_request_unit.md
TRAFFIC_REQUEST_UNIT -- requirements
Module: traffic_request_unit

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles before a debounced input changes; legal range 1..65535.
REQ-002 Parameter MIN_GREEN_CYCLES, default 500: minimum cycles in phase 0 (north green) before a sensor request is issued; legal range 1..65535.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 sensor_raw  input  1  vehicle-sensor pad, asynchronous, may bounce.
REQ-006 emerg_raw  input  1  emergency-request pad, asynchronous, may bounce.
REQ-007 phase  input  3  current phase code from the intersection controller; 0 = north green, 1..7 = other phases.
REQ-008 go_control  output  2  registered to the controller; bit 0 = sensor request, bit 1 = emergency request.
REQ-009 req_pending  output  1  high while any request latch is set.
REQ-010 emerg_active  output  1  high while the emergency latch is set.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced value flips only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle resets the count.
REQ-012 Pulses or gaps shorter than DEBOUNCE_CYCLES SHALL produce no debounced change.
REQ-013 A debounced rising edge SHALL set the matching latch (sensor_req, emerg_req) on the next edge; falling edges SHALL not clear latches.
REQ-014 Min-green counter SHALL increment each cycle phase==0, saturate at MIN_GREEN_CYCLES, and clear to 0 in any cycle phase!=0.
REQ-015 FSM states: IDLE, HOLD, ASSERT, DRAIN.
REQ-016 IDLE -> HOLD when any latch is set; HOLD -> ASSERT when phase==0 and (emerg_req or counter==MIN_GREEN_CYCLES); emergency bypasses min-green.
REQ-017 In ASSERT, go_control SHALL equal {emerg_req, sensor_req}; in all other states go_control SHALL be 2'b00.
REQ-018 ASSERT -> DRAIN on the first cycle phase!=0; on that edge both latches clear (request consumed).
REQ-019 A debounced rising edge coinciding with the consuming edge SHALL leave its latch set (set wins over clear).
REQ-020 DRAIN: new requests latch but are not issued; DRAIN -> HOLD when phase==0 and any latch set, DRAIN -> IDLE when phase==0 and no latch set.
REQ-021 An emergency edge arriving while in HOLD waiting for min-green SHALL cause ASSERT on the following edge with go_control=2'b11 if sensor_req also set.
REQ-022 End-to-end latency from raw rising edge to go_control assertion, from IDLE with phase==0 and min-green saturated, SHALL be exactly DEBOUNCE_CYCLES+4 cycles.
REQ-023 Debounce and min-green counters SHALL be 16 bits and never wrap.

Reset
REQ-024 On resetn low at a clk edge: state IDLE, latches 0, go_control 2'b00, req_pending 0, emerg_active 0, counters 0, synchronizer flops 0, debounced values 0.
REQ-025 Reset mid-operation (any state) SHALL discard pending requests; a raw input held high through reset deassertion SHALL be treated as a new rising edge after DEBOUNCE_CYCLES.

Structure
REQ-026 Phase codes (N_GREEN=0 ... N_LEFT=7) and the FSM state encoding SHALL live in shared package traffic_pkg, also used by the controller.
REQ-027 Synchronizer plus debouncer SHALL be one sub-module, input_debounce, instantiated twice.

Verification (DEBOUNCE_CYCLES=4, MIN_GREEN_CYCLES=10)
REQ-028 Sensor high held, phase=0 for 20 cycles before -> go_control=2'b01 exactly 8 cycles after the raw edge.
REQ-029 Sensor glitch of 3 cycles -> go_control stays 2'b00, req_pending stays 0.
REQ-030 Sensor debounced 2 cycles after phase enters 0 -> go_control=2'b01 only when the min-green counter reaches 10; phase set to 1 -> go_control 2'b00 next cycle, latch cleared.
REQ-031 Sensor pending in HOLD, emergency raised -> go_control=2'b11 at first ASSERT cycle, emerg_active=1.
REQ-032 Sensor edge during DRAIN (phase=3) -> no go_control; phase returns to 0 -> HOLD, request reissued after 10 cycles.
REQ-033 resetn low for 1 cycle while in ASSERT -> all outputs 0 next cycle, state IDLE.
